// File: rtl/acq_sequencer_if.sv
// rtl/acq_sequencer_if.sv - dispatcher handshake, probe/config inputs and sample RAM write port of the capture controller
interface acq_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              grant_i;
  logic              done_o;
  logic [DATA_W-1:0] probe_i;
  logic              sample_en_i;
  logic [DATA_W-1:0] trig_mask_i;
  logic [DATA_W-1:0] trig_value_i;
  logic [ADDR_W-1:0] pre_len_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [ADDR_W-1:0] start_addr_o;
  logic              triggered_o;
  logic              busy_o;

  modport slave (
    input  grant_i, probe_i, sample_en_i, trig_mask_i, trig_value_i, pre_len_i,
    output done_o, wr_en_o, wr_addr_o, wr_data_o, start_addr_o, triggered_o, busy_o
  );

  modport master (
    output grant_i, probe_i, sample_en_i, trig_mask_i, trig_value_i, pre_len_i,
    input  done_o, wr_en_o, wr_addr_o, wr_data_o, start_addr_o, triggered_o, busy_o
  );
endinterface

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - pre-trigger / masked trigger / post-trigger capture into a circular sample buffer
module acq_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  acq_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE,
    S_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              trig_q, trig_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              active;
  logic              match;

  assign active = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign match  = ((bus.probe_i ^ value_q) & mask_q) == '0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    start_d   = start_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mask_d    = mask_q;
    value_d   = value_q;
    trig_d    = trig_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.grant_i) begin
          // pre_len is ADDR_W bits wide, so it can never exceed DEPTH-1
          mask_d  = bus.trig_mask_i;
          value_d = bus.trig_value_i;
          pre_d   = bus.pre_len_i;
          cnt_d   = bus.pre_len_i;
          addr_d  = '0;
          trig_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = (bus.pre_len_i == '0) ? S_ARMED : S_PRE;
        end
      end

      S_PRE, S_ARMED, S_POST: begin
        if (!bus.grant_i) begin
          // abort wins over a coincident sample strobe
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (bus.sample_en_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.probe_i;
          addr_d    = addr_q + ADDR_W'(1);
          if (state_q == S_PRE) begin
            cnt_d = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) state_d = S_ARMED;
          end else if (state_q == S_ARMED) begin
            if (match) begin
              trig_d  = 1'b1;
              start_d = addr_q - pre_q;
              // remaining post-trigger samples: DEPTH-1-pre_eff
              cnt_d   = ~pre_q;
              state_d = (pre_q == '1) ? S_DONE : S_POST;
            end
          end else begin
            cnt_d = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_RELEASE;
      end

      S_RELEASE: begin
        if (!bus.grant_i) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      start_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      wr_en_q   <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      start_q   <= start_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      wr_en_q   <= wr_en_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.done_o       = done_q;
  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.start_addr_o = start_q;
  assign bus.triggered_o  = trig_q;
  assign bus.busy_o       = busy_q && active || busy_q && (state_q == S_DONE);

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - randomized capture scenarios checked against a buffer-level reference model
module tb_acq_sequencer;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int H      = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acq_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  acq_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic       stim_en [H];
  logic [7:0] stim_pr [H];

  // Model: accepted samples fill addresses 0,1,2.. mod DEPTH; the first match at or
  // after index pre_eff is the trigger; capture ends pre_eff+... +(DEPTH-1-pre_eff) later.
  task automatic run_capture(input logic [3:0] pre, input logic [7:0] mask, input logic [7:0] value,
                             input int exp_start_c, input int exp_total_c, input string name);
    int         acc [$];
    int         pre_eff, t, total, done_obs, trig_obs, busy_end, seen;
    logic       exp_wr   [H+4];
    logic [3:0] exp_addr [H+4];
    logic [7:0] exp_data [H+4];
    logic [3:0] exp_start;
    logic       complete;

    for (int k = 0; k < H - 1; k++) if (stim_en[k]) acc.push_back(k);
    pre_eff = (int'(pre) > DEPTH - 1) ? DEPTH - 1 : int'(pre);
    t = -1;
    for (int i = pre_eff; i < acc.size(); i++)
      if ((stim_pr[acc[i]] & mask) == (value & mask)) begin t = i; break; end
    total    = (t < 0) ? acc.size() : t + 1 + (DEPTH - 1 - pre_eff);
    complete = (t >= 0) && (acc.size() >= total);
    if (total > acc.size()) total = acc.size();
    for (int k = 0; k < H + 4; k++) begin exp_wr[k] = 1'b0; exp_addr[k] = '0; exp_data[k] = '0; end
    for (int i = 0; i < total; i++) begin
      exp_wr[acc[i] + 1]   = 1'b1;
      exp_addr[acc[i] + 1] = 4'(i % DEPTH);
      exp_data[acc[i] + 1] = stim_pr[acc[i]];
    end
    trig_obs  = (t >= 0) ? acc[t] + 1 : 1 << 30;
    exp_start = (t >= 0) ? 4'(((t % DEPTH) - pre_eff + DEPTH) % DEPTH) : 4'd0;
    done_obs  = complete ? acc[total - 1] + 2 : -1;
    busy_end  = complete ? done_obs : H + 1;
    seen = 0;

    bus.grant_i = 1'b1; bus.trig_mask_i = mask; bus.trig_value_i = value; bus.pre_len_i = pre;
    bus.sample_en_i = 1'b0; bus.probe_i = '0;
    @(posedge clk); #1;
    bus.trig_mask_i = 8'($urandom); bus.trig_value_i = 8'($urandom); bus.pre_len_i = 4'($urandom);
    for (int k = 0; k < H + 4; k++) begin
      bus.grant_i     = (k < H);
      bus.sample_en_i = (k < H - 1) ? stim_en[k] : 1'b0;
      bus.probe_i     = (k < H - 1) ? stim_pr[k] : 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus.wr_en_o !== exp_wr[k]) $display("FAIL %s wr_en it=%0d got %b want %b", name, k, bus.wr_en_o, exp_wr[k]);
      else n_pass++;
      if (exp_wr[k]) begin
        n_checks++;
        if (bus.wr_addr_o !== exp_addr[k]) $display("FAIL %s wr_addr it=%0d got %0d want %0d", name, k, bus.wr_addr_o, exp_addr[k]);
        else n_pass++;
        n_checks++;
        if (bus.wr_data_o !== exp_data[k]) $display("FAIL %s wr_data it=%0d got %h want %h", name, k, bus.wr_data_o, exp_data[k]);
        else n_pass++;
      end
      if (bus.wr_en_o === 1'b1) seen++;
      n_checks++;
      if (bus.done_o !== (k == done_obs)) $display("FAIL %s done it=%0d got %b want %b", name, k, bus.done_o, (k == done_obs));
      else n_pass++;
      n_checks++;
      if (bus.busy_o !== (k < busy_end)) $display("FAIL %s busy it=%0d got %b want %b", name, k, bus.busy_o, (k < busy_end));
      else n_pass++;
      n_checks++;
      if (bus.triggered_o !== (k >= trig_obs)) $display("FAIL %s triggered it=%0d got %b want %b", name, k, bus.triggered_o, (k >= trig_obs));
      else n_pass++;
      if (k >= trig_obs) begin
        n_checks++;
        if (bus.start_addr_o !== exp_start) $display("FAIL %s start_addr it=%0d got %0d want %0d", name, k, bus.start_addr_o, exp_start);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != ((exp_total_c >= 0) ? exp_total_c : total))
      $display("FAIL %s write_count got %0d want %0d", name, seen, (exp_total_c >= 0) ? exp_total_c : total);
    else n_pass++;
    if (exp_start_c >= 0) begin
      n_checks++;
      if (int'(bus.start_addr_o) != exp_start_c) $display("FAIL %s final_start got %0d want %0d", name, bus.start_addr_o, exp_start_c);
      else n_pass++;
    end
  endtask

  task automatic fill_random(input logic [7:0] value);
    for (int k = 0; k < H; k++) begin
      stim_en[k] = ($urandom_range(0, 3) != 0);
      stim_pr[k] = ($urandom_range(0, 3) == 0) ? value : 8'($urandom);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL %s done got %b want 0", name, bus.done_o); else n_pass++;
    n_checks++; if (bus.wr_en_o !== 1'b0) $display("FAIL %s wr_en got %b want 0", name, bus.wr_en_o); else n_pass++;
    n_checks++; if (bus.wr_addr_o !== 4'd0) $display("FAIL %s wr_addr got %0d want 0", name, bus.wr_addr_o); else n_pass++;
    n_checks++; if (bus.wr_data_o !== 8'd0) $display("FAIL %s wr_data got %h want 00", name, bus.wr_data_o); else n_pass++;
    n_checks++; if (bus.start_addr_o !== 4'd0) $display("FAIL %s start_addr got %0d want 0", name, bus.start_addr_o); else n_pass++;
    n_checks++; if (bus.triggered_o !== 1'b0) $display("FAIL %s triggered got %b want 0", name, bus.triggered_o); else n_pass++;
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL %s busy got %b want 0", name, bus.busy_o); else n_pass++;
  endtask

  task automatic test_reset();
    bus.grant_i = 1'b0; bus.probe_i = '0; bus.sample_en_i = 1'b0;
    bus.trig_mask_i = '0; bus.trig_value_i = '0; bus.pre_len_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < H; k++) begin stim_en[k] = 1'b1; stim_pr[k] = 8'(k); end
    run_capture(4'd4, 8'hFF, 8'h0A, 6, 22, "basic");
  endtask

  task automatic test_zero_pre();
    for (int k = 0; k < H; k++) begin stim_en[k] = 1'b1; stim_pr[k] = 8'($urandom); end
    run_capture(4'd0, 8'h00, 8'h00, 0, 16, "zero_pre");
  endtask

  task automatic test_trig_ignored_in_pre();
    for (int k = 0; k < H; k++) begin
      stim_en[k] = 1'b1;
      stim_pr[k] = (k < 4 || k == 7) ? 8'h5A : (k < 7 ? 8'h00 : 8'($urandom));
    end
    run_capture(4'd4, 8'hFF, 8'h5A, 3, 19, "trig_in_pre");
  endtask

  task automatic test_abort();
    bus.grant_i = 1'b1; bus.pre_len_i = 4'd2; bus.trig_mask_i = 8'hFF; bus.trig_value_i = 8'hAA;
    bus.probe_i = 8'h00; bus.sample_en_i = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    bus.grant_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (bus.wr_en_o !== 1'b0) $display("FAIL abort wr_en it=%0d got %b want 0", k, bus.wr_en_o); else n_pass++;
      n_checks++; if (bus.done_o !== 1'b0) $display("FAIL abort done it=%0d got %b want 0", k, bus.done_o); else n_pass++;
      n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL abort busy it=%0d got %b want 0", k, bus.busy_o); else n_pass++;
      n_checks++; if (bus.triggered_o !== 1'b0) $display("FAIL abort triggered it=%0d got %b want 0", k, bus.triggered_o); else n_pass++;
    end
    @(posedge clk); #1;
    bus.sample_en_i = 1'b0;
    fill_random(8'h3C);
    run_capture(4'($urandom), 8'hF0, 8'h3C, -1, -1, "after_abort");
  endtask

  task automatic test_clamp_release();
    for (int k = 0; k < H; k++) begin stim_en[k] = 1'b1; stim_pr[k] = 8'($urandom); end
    run_capture(4'd15, 8'h00, 8'h00, 0, 16, "clamp_release");
  endtask

  task automatic test_reset_in_post();
    bus.grant_i = 1'b1; bus.pre_len_i = 4'd0; bus.trig_mask_i = 8'h00; bus.trig_value_i = 8'h00;
    bus.sample_en_i = 1'b1; bus.probe_i = 8'hC3;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_in_post");
    @(posedge clk); #1;
    bus.sample_en_i = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < H; k++) begin stim_en[k] = 1'b1; stim_pr[k] = 8'($urandom); end
    run_capture(4'd5, 8'h00, 8'h00, 0, 16, "restart_after_reset");
  endtask

  task automatic test_random_captures();
    logic [7:0] m, v;
    for (int r = 0; r < 8; r++) begin
      m = 8'($urandom & $urandom & $urandom);
      v = 8'($urandom);
      fill_random(v);
      run_capture(4'($urandom), m, v, -1, -1, $sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_pre();
    test_trig_ignored_in_pre();
    test_abort();
    test_clamp_release();
    test_reset_in_post();
    test_random_captures();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
